// File: rtl/pipelined_datapath.sv
// ---------------------------------------------------------------------------
// pipelined_datapath
//   Five-stage (IF, ID, EX, MEM, WB) 32-bit datapath with no interlocks.
//   One instruction issues per cycle. Control transfers resolve in MEM.
//   A taken transfer flushes the three younger instructions.
//
//   Ports:
//     clk   - single clock, all state updates on the rising edge
//     reset - synchronous, active-high; clears PC, flags and every
//             pipeline valid bit (memories and register file keep contents)
//
//   Hierarchy: inst_mem.mem, data_mem.d_mem, reg_file.rf (64 x 32).
//
//   Build option: define FORWARD_EN to add EX operand forwarding from
//   EX/MEM (ALU/SVPC results) and MEM/WB (any result).
// ---------------------------------------------------------------------------

module pd_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] addr,
    output logic [31:0]   data
);
    logic [31:0] mem [DEPTH];

    // Write port exists for completeness; the datapath holds it idle.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign data = mem[addr];
endmodule

module pd_dmem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] d_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) d_mem[addr] <= wdata;
    end

    assign rdata = d_mem[addr];
endmodule

module pd_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  ra1,
    input  logic [5:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] rf [64];

    always_ff @(posedge clk) begin
        if (we) rf[waddr] <= wdata;
    end

    // Write-through: a same-cycle read of the register being written
    // returns the new value.
    assign rd1 = (we && (waddr == ra1)) ? wdata : rf[ra1];
    assign rd2 = (we && (waddr == ra2)) ? wdata : rf[ra2];
endmodule

module pipelined_datapath #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input logic clk,
    input logic reset
);
    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);

    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return $signed({{16{v[15]}}, v});
    endfunction

    function automatic logic signed [31:0] sext22(input logic [21:0] v);
        return $signed({{10{v[21]}}, v});
    endfunction

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NEG) || (op == OP_INC);
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return is_alu(op) || (op == OP_LD) || (op == OP_SVPC);
    endfunction

    logic [31:0] pc;
    logic [31:0] instr_if;
    logic        z_flag, n_flag;

    // IF/ID
    logic        vld_p0;
    logic [31:0] instr_p0, pc_p0;
    logic [31:0] rs_val_id, rt_val_id;

    // ID/EX
    logic               vld_p1;
    logic [3:0]         op_p1;
    logic [5:0]         rd_p1;
`ifdef FORWARD_EN
    logic [5:0]         rs_p1, rt_p1;
`endif
    logic signed [31:0] a_p1, b_p1;
    logic [21:0]        imm_p1;
    logic [31:0]        pc_p1;
    logic signed [31:0] a_ex, b_ex, res_ex;

    // EX/MEM
    logic               vld_p2;
    logic [3:0]         op_p2;
    logic [5:0]         rd_p2;
    logic signed [31:0] res_p2, a_p2, b_p2;
    logic [31:0]        dm_rdata;
    logic               take_mem;
    logic [31:0]        target_mem;
    logic               dm_we;

    // MEM/WB
    logic        vld_p3;
    logic [3:0]  op_p3;
    logic [5:0]  rd_p3;
    logic [31:0] wdata_p3;
    logic        rf_we;

    pd_imem #(.DEPTH(IMEM_DEPTH), .AW(IA_W)) inst_mem (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .addr  (pc[IA_W-1:0]),
        .data  (instr_if)
    );

    pd_regfile reg_file (
        .clk   (clk),
        .we    (rf_we),
        .waddr (rd_p3),
        .wdata (wdata_p3),
        .ra1   (instr_p0[21:16]),
        .ra2   (instr_p0[15:10]),
        .rd1   (rs_val_id),
        .rd2   (rt_val_id)
    );

    pd_dmem #(.DEPTH(DMEM_DEPTH), .AW(DA_W)) data_mem (
        .clk   (clk),
        .we    (dm_we),
        .addr  (a_p2[DA_W-1:0]),
        .wdata (b_p2),
        .rdata (dm_rdata)
    );

    // EX stage: operand selection and ALU
    always_comb begin
        a_ex = a_p1;
        b_ex = b_p1;
`ifdef FORWARD_EN
        // EX/MEM holds the younger producer, so it wins over MEM/WB.
        // Loads are not forwarded from EX/MEM: their data is not read yet.
        if (vld_p2 && writes_rd(op_p2) && (op_p2 != OP_LD) && (rd_p2 == rs_p1))
            a_ex = res_p2;
        else if (vld_p3 && writes_rd(op_p3) && (rd_p3 == rs_p1))
            a_ex = $signed(wdata_p3);
        if (vld_p2 && writes_rd(op_p2) && (op_p2 != OP_LD) && (rd_p2 == rt_p1))
            b_ex = res_p2;
        else if (vld_p3 && writes_rd(op_p3) && (rd_p3 == rt_p1))
            b_ex = $signed(wdata_p3);
`endif
        case (op_p1)
            OP_ADD:  res_ex = a_ex + b_ex;
            OP_SUB:  res_ex = a_ex - b_ex;
            OP_NEG:  res_ex = -a_ex;
            OP_INC:  res_ex = a_ex + sext16(imm_p1[15:0]);
            OP_SVPC: res_ex = $signed(pc_p1) + sext22(imm_p1);
            default: res_ex = '0;
        endcase
    end

    // MEM stage: transfer resolution against the current flags
    always_comb begin
        take_mem   = 1'b0;
        target_mem = a_p2;
        if (vld_p2) begin
            case (op_p2)
                OP_J:   take_mem = 1'b1;
                OP_JM: begin
                    take_mem   = 1'b1;
                    target_mem = dm_rdata;
                end
                OP_BRZ: take_mem = z_flag;
                OP_BRN: take_mem = n_flag;
                default: take_mem = 1'b0;
            endcase
        end
    end

    // Reset gates both write ports so nothing commits on the reset edge.
    assign dm_we = vld_p2 && (op_p2 == OP_ST) && !reset;
    assign rf_we = vld_p3 && writes_rd(op_p3) && !reset;

    // Control state: PC, flags, valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            pc     <= take_mem ? target_mem : pc + 32'd1;
            vld_p0 <= !take_mem;
            vld_p1 <= vld_p0 && !take_mem;
            vld_p2 <= vld_p1 && !take_mem;
            vld_p3 <= vld_p2;
            // The EX instruction killed by a taken transfer leaves flags alone.
            if (vld_p1 && is_alu(op_p1) && !take_mem) begin
                z_flag <= (res_ex == 0);
                n_flag <= res_ex[31];
            end
        end
    end

    // Datapath registers (qualified by the valid bits above)
    always_ff @(posedge clk) begin
        // IF -> ID
        instr_p0 <= instr_if;
        pc_p0    <= pc;
        // ID -> EX
        op_p1    <= instr_p0[31:28];
        rd_p1    <= instr_p0[27:22];
`ifdef FORWARD_EN
        rs_p1    <= instr_p0[21:16];
        rt_p1    <= instr_p0[15:10];
`endif
        a_p1     <= $signed(rs_val_id);
        b_p1     <= $signed(rt_val_id);
        imm_p1   <= instr_p0[21:0];
        pc_p1    <= pc_p0;
        // EX -> MEM
        op_p2    <= op_p1;
        rd_p2    <= rd_p1;
        res_p2   <= res_ex;
        a_p2     <= a_ex;
        b_p2     <= b_ex;
        // MEM -> WB
        op_p3    <= op_p2;
        rd_p3    <= rd_p2;
        wdata_p3 <= (op_p2 == OP_LD) ? dm_rdata : res_p2;
    end
endmodule

// File: tb/tb_pipelined_datapath.sv
module tb_pipelined_datapath;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    pipelined_datapath dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
        int          rd;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] enc_r(input logic [3:0] op, input int rd, input int rs, input int rt);
        logic [5:0] d, s, t;
        d = rd[5:0]; s = rs[5:0]; t = rt[5:0];
        return {op, d, s, t, 10'b0};
    endfunction

    function automatic logic [31:0] enc_i16(input logic [3:0] op, input int rd, input int rs, input logic [15:0] imm);
        logic [5:0] d, s;
        d = rd[5:0]; s = rs[5:0];
        return {op, d, s, imm};
    endfunction

    function automatic logic [31:0] enc_i22(input logic [3:0] op, input int rd, input logic [21:0] imm);
        logic [5:0] d;
        d = rd[5:0];
        return {op, d, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds reset, then zeroes all three memories while the pipeline is idle.
    task automatic reset_and_clear();
        reset = 1'b1;
        step(2);
        for (int i = 0; i < 256; i++) begin
            dut.inst_mem.mem[i] = '0;
            dut.data_mem.d_mem[i] = '0;
        end
        for (int i = 0; i < 64; i++) dut.reg_file.rf[i] = '0;
    endtask

    task automatic branch_test(input logic [3:0] op, input int ra, input int rb, input bit taken);
        string t;
        t = $sformatf("br op%b x%0d-x%0d", op, ra, rb);
        reset_and_clear();
        dut.reg_file.rf[1] = 32'd5;
        dut.reg_file.rf[2] = 32'd3;
        dut.reg_file.rf[6] = 32'd10;
        dut.inst_mem.mem[0]  = enc_r(OP_SUB, 3, ra, rb);
        dut.inst_mem.mem[1]  = enc_r(op, 0, 6, 0);
        dut.inst_mem.mem[2]  = enc_r(OP_ST, 0, 1, 1);
        dut.inst_mem.mem[3]  = enc_i16(OP_INC, 8, 1, 16'd1);
        dut.inst_mem.mem[4]  = enc_i16(OP_INC, 9, 1, 16'd1);
        dut.inst_mem.mem[5]  = enc_i16(OP_INC, 11, 1, 16'd1);
        dut.inst_mem.mem[10] = enc_i16(OP_INC, 10, 1, 16'd1);
        reset = 1'b0;
        step(11);
        check({t, " rf8"},  dut.reg_file.rf[8],  taken ? 32'd0 : 32'd6);
        check({t, " rf9"},  dut.reg_file.rf[9],  taken ? 32'd0 : 32'd6);
        check({t, " dm5"},  dut.data_mem.d_mem[5], taken ? 32'd0 : 32'd5);
        check({t, " rf11"}, dut.reg_file.rf[11], taken ? 32'd0 : 32'd6);
        check({t, " rf10"}, dut.reg_file.rf[10], taken ? 32'd6 : 32'd0);
    endtask

    task automatic jump_test(input logic [3:0] op);
        string t;
        t = $sformatf("jump op%b", op);
        reset_and_clear();
        dut.reg_file.rf[1] = 32'd5;
        dut.reg_file.rf[6] = 32'd12;
        dut.data_mem.d_mem[5] = 32'd12;
        dut.inst_mem.mem[0]  = enc_r(op, 0, (op == OP_J) ? 6 : 1, 0);
        dut.inst_mem.mem[1]  = enc_i16(OP_INC, 7, 1, 16'd1);
        dut.inst_mem.mem[2]  = enc_i16(OP_INC, 8, 1, 16'd1);
        dut.inst_mem.mem[3]  = enc_i16(OP_INC, 9, 1, 16'd1);
        dut.inst_mem.mem[12] = enc_i16(OP_INC, 10, 1, 16'd1);
        reset = 1'b0;
        step(10);
        check({t, " target rf10"}, dut.reg_file.rf[10], 32'd6);
        check({t, " rf7"}, dut.reg_file.rf[7], 32'd0);
        check({t, " rf8"}, dut.reg_file.rf[8], 32'd0);
        check({t, " rf9"}, dut.reg_file.rf[9], 32'd0);
    endtask

    // Random straight-line programs against a sequential ISA interpreter.
    task automatic random_test(input int run);
        localparam int L = 40;
        logic [3:0]  ops[8];
        logic [31:0] mrf[64];
        logic [31:0] mdm[256];
        logic [3:0]  op;
        int          rd, rs, rt, w1, w2, wnew;
        bit          ok, use_rs, use_rt;
        logic [15:0] i16;
        logic [21:0] i22;
        logic [31:0] iw;
        ops = '{OP_ADD, OP_SUB, OP_NEG, OP_INC, OP_LD, OP_ST, OP_SVPC, OP_NOP};
        reset_and_clear();
        for (int i = 0; i < 64; i++) mrf[i] = (i < 16) ? $urandom : 32'd0;
        for (int i = 0; i < 256; i++) mdm[i] = $urandom;
        for (int i = 0; i < 64; i++) dut.reg_file.rf[i] = mrf[i];
        for (int i = 0; i < 256; i++) dut.data_mem.d_mem[i] = mdm[i];
        w1 = -1; w2 = -1;
        for (int pc = 0; pc < L; pc++) begin
            ok = 1'b0;
            op = OP_NOP; rd = 0; rs = 0; rt = 0;
            for (int tries = 0; tries < 50 && !ok; tries++) begin
                op = ops[$urandom_range(0, 7)];
                rd = $urandom_range(0, 15);
                rs = $urandom_range(0, 15);
                rt = $urandom_range(0, 15);
                use_rs = (op == OP_ADD) || (op == OP_SUB) || (op == OP_NEG) ||
                         (op == OP_INC) || (op == OP_LD) || (op == OP_ST);
                use_rt = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ST);
                // Keep every consumer at least three instructions behind its producer.
                ok = !(use_rs && (rs == w1 || rs == w2)) && !(use_rt && (rt == w1 || rt == w2));
            end
            if (!ok) op = OP_NOP;
            i16 = 16'($urandom);
            i22 = 22'($urandom);
            wnew = -1;
            case (op)
                OP_ADD:  begin iw = enc_r(op, rd, rs, rt); mrf[rd] = mrf[rs] + mrf[rt]; wnew = rd; end
                OP_SUB:  begin iw = enc_r(op, rd, rs, rt); mrf[rd] = mrf[rs] - mrf[rt]; wnew = rd; end
                OP_NEG:  begin iw = enc_r(op, rd, rs, 0);  mrf[rd] = 32'd0 - mrf[rs]; wnew = rd; end
                OP_INC:  begin iw = enc_i16(op, rd, rs, i16); mrf[rd] = mrf[rs] + {{16{i16[15]}}, i16}; wnew = rd; end
                OP_LD:   begin iw = enc_r(op, rd, rs, 0); mrf[rd] = mdm[mrf[rs] % 256]; wnew = rd; end
                OP_ST:   begin iw = enc_r(op, 0, rs, rt); mdm[mrf[rs] % 256] = mrf[rt]; end
                OP_SVPC: begin iw = enc_i22(op, rd, i22); mrf[rd] = pc + {{10{i22[21]}}, i22}; wnew = rd; end
                default: iw = 32'd0;
            endcase
            dut.inst_mem.mem[pc] = iw;
            w2 = w1; w1 = wnew;
        end
        reset = 1'b0;
        step(L + 6);
        for (int i = 0; i < 16; i++)
            check($sformatf("rand%0d rf[%0d]", run, i), dut.reg_file.rf[i], mrf[i]);
        for (int i = 0; i < 256; i++)
            check($sformatf("rand%0d dm[%0d]", run, i), dut.data_mem.d_mem[i], mdm[i]);
    endtask

    initial begin
        vecs[0]  = '{enc_r(OP_ADD, 4, 1, 2),  32'd5, 32'd3, 4, 32'd8};
        vecs[1]  = '{enc_r(OP_SUB, 3, 1, 2),  32'd5, 32'd3, 3, 32'd2};
        vecs[2]  = '{enc_r(OP_NEG, 4, 1, 0),  32'd5, 32'd0, 4, 32'hFFFF_FFFB};
        vecs[3]  = '{enc_i16(OP_INC, 4, 1, 16'd1),    32'd5, 32'd0, 4, 32'd6};
        vecs[4]  = '{enc_i16(OP_INC, 4, 1, 16'hFFFF), 32'd5, 32'd0, 4, 32'd4};
        vecs[5]  = '{enc_r(OP_ADD, 4, 1, 2),  32'h7FFF_FFFF, 32'd1, 4, 32'h8000_0000};
        vecs[6]  = '{enc_r(OP_SUB, 4, 1, 2),  32'd0, 32'd1, 4, 32'hFFFF_FFFF};
        vecs[7]  = '{enc_i22(OP_SVPC, 4, 22'd2),        32'd0, 32'd0, 4, 32'd2};
        vecs[8]  = '{enc_i22(OP_SVPC, 4, 22'h3F_FFFD),  32'd0, 32'd0, 4, 32'hFFFF_FFFD};
        vecs[9]  = '{enc_r(4'b0010, 1, 1, 2), 32'd5, 32'd3, 1, 32'd5};
        vecs[10] = '{enc_r(OP_NEG, 4, 1, 0),  32'h8000_0000, 32'd0, 4, 32'h8000_0000};

        for (int i = 0; i < 11; i++) begin
            reset_and_clear();
            dut.inst_mem.mem[0] = vecs[i].instr;
            dut.reg_file.rf[1] = vecs[i].r1;
            dut.reg_file.rf[2] = vecs[i].r2;
            reset = 1'b0;
            step(5);
            check($sformatf("vec%0d rf[%0d]", i, vecs[i].rd), dut.reg_file.rf[vecs[i].rd], vecs[i].expv);
        end

        // Commit timing: rf after the 5th edge, d_mem after the 4th; then load.
        reset_and_clear();
        dut.reg_file.rf[1] = 32'd5;
        dut.reg_file.rf[2] = 32'd3;
        dut.inst_mem.mem[0] = enc_r(OP_ST, 0, 1, 2);
        dut.inst_mem.mem[4] = enc_r(OP_LD, 4, 1, 0);
        reset = 1'b0;
        step(3);
        check("st before 4th edge", dut.data_mem.d_mem[5], 32'd0);
        step(1);
        check("st after 4th edge", dut.data_mem.d_mem[5], 32'd3);
        step(4);
        check("ld before 5th edge", dut.reg_file.rf[4], 32'd0);
        step(1);
        check("ld after 5th edge", dut.reg_file.rf[4], 32'd3);

        // SVPC, then reset: PC back to 0, flags clear, rf untouched, re-execution.
        reset_and_clear();
        dut.reg_file.rf[1] = 32'd5;
        dut.inst_mem.mem[0] = enc_i22(OP_SVPC, 4, 22'd2);
        dut.inst_mem.mem[1] = enc_r(OP_NEG, 5, 1, 0);
        reset = 1'b0;
        step(5);
        check("svpc rf4", dut.reg_file.rf[4], 32'd2);
        check("pc free-run", dut.pc, 32'd5);
        check("n flag after neg", {31'd0, dut.n_flag}, 32'd1);
        reset = 1'b1;
        step(1);
        check("pc after reset", dut.pc, 32'd0);
        check("n flag after reset", {31'd0, dut.n_flag}, 32'd0);
        check("rf4 kept over reset", dut.reg_file.rf[4], 32'd2);
        dut.reg_file.rf[4] = 32'd0;
        reset = 1'b0;
        step(5);
        check("svpc re-executed", dut.reg_file.rf[4], 32'd2);

        // Reset landing on the WB edge of an ADD and the MEM edge of an ST.
        reset_and_clear();
        dut.reg_file.rf[1] = 32'd5;
        dut.reg_file.rf[2] = 32'd3;
        dut.inst_mem.mem[0] = enc_r(OP_ADD, 4, 1, 2);
        dut.inst_mem.mem[1] = enc_r(OP_ST, 0, 1, 2);
        reset = 1'b0;
        step(4);
        reset = 1'b1;
        step(4);
        check("reset kills wb", dut.reg_file.rf[4], 32'd0);
        check("reset kills st", dut.data_mem.d_mem[5], 32'd0);

        branch_test(OP_BRZ, 1, 1, 1'b1);
        branch_test(OP_BRN, 1, 1, 1'b0);
        branch_test(OP_BRN, 2, 1, 1'b1);
        branch_test(OP_BRZ, 1, 2, 1'b0);
        jump_test(OP_J);
        jump_test(OP_JM);

        // Flushed EX instruction must not disturb Z for the next BRZ.
        reset_and_clear();
        dut.reg_file.rf[1] = 32'd5;
        dut.reg_file.rf[6] = 32'd10;
        dut.reg_file.rf[12] = 32'd20;
        dut.inst_mem.mem[0]  = enc_r(OP_SUB, 3, 1, 1);
        dut.inst_mem.mem[1]  = enc_r(OP_BRZ, 0, 6, 0);
        dut.inst_mem.mem[2]  = enc_i16(OP_INC, 7, 1, 16'd1);
        dut.inst_mem.mem[10] = enc_r(OP_BRZ, 0, 12, 0);
        dut.inst_mem.mem[11] = enc_i16(OP_INC, 14, 1, 16'd1);
        dut.inst_mem.mem[20] = enc_i16(OP_INC, 13, 1, 16'd1);
        reset = 1'b0;
        step(16);
        check("flush keeps Z: rf13", dut.reg_file.rf[13], 32'd6);
        check("flush keeps Z: rf14", dut.reg_file.rf[14], 32'd0);
        check("flush keeps Z: rf7", dut.reg_file.rf[7], 32'd0);

        // Back-to-back ALU dependency.
        reset_and_clear();
        dut.reg_file.rf[1] = 32'd5;
        dut.reg_file.rf[2] = 32'd3;
        dut.inst_mem.mem[0] = enc_r(OP_ADD, 4, 1, 2);
        dut.inst_mem.mem[1] = enc_r(OP_ADD, 5, 4, 4);
        reset = 1'b0;
        step(7);
`ifdef FORWARD_EN
        check("adjacent dep rf5", dut.reg_file.rf[5], 32'd16);
`else
        check("adjacent dep rf5", dut.reg_file.rf[5], 32'd0);
`endif

        // Distance-3 dependency through the register file write-through.
        reset_and_clear();
        dut.reg_file.rf[1] = 32'd5;
        dut.reg_file.rf[2] = 32'd3;
        dut.inst_mem.mem[0] = enc_r(OP_ADD, 4, 1, 2);
        dut.inst_mem.mem[3] = enc_r(OP_ADD, 5, 4, 4);
        reset = 1'b0;
        step(9);
        check("distance3 rf5", dut.reg_file.rf[5], 32'd16);

        // Load-use with one intervening instruction.
        reset_and_clear();
        dut.reg_file.rf[1] = 32'd5;
        dut.data_mem.d_mem[5] = 32'd7;
        dut.inst_mem.mem[0] = enc_r(OP_LD, 4, 1, 0);
        dut.inst_mem.mem[2] = enc_r(OP_ADD, 5, 4, 4);
        reset = 1'b0;
        step(8);
`ifdef FORWARD_EN
        check("load-use rf5", dut.reg_file.rf[5], 32'd14);
`else
        check("load-use rf5", dut.reg_file.rf[5], 32'd0);
`endif

        for (int r = 0; r < 3; r++) random_test(r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
